// File: rtl/perf_monitor_pkg.sv
// Shared types for perf_monitor: channel state encoding, per-channel start/stop window,
// and the nibble codes the hex overlay shows for each state.
package perf_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RUNNING = 2'd2,
      DONE    = 2'd3
   } perf_state_t;

   // Windows are stored zero-extended to this width so the struct is parameter independent.
   localparam int PERF_PC_MAX_W = 32;

   typedef struct packed {
      logic [PERF_PC_MAX_W-1:0] start_pc;
      logic [PERF_PC_MAX_W-1:0] stop_pc;
   } perf_cfg_t;

   localparam logic [3:0] HEX_IDLE    = 4'h0;
   localparam logic [3:0] HEX_ARMED   = 4'h1;
   localparam logic [3:0] HEX_RUNNING = 4'h2;
   localparam logic [3:0] HEX_DONE    = 4'h3;

   function automatic logic [3:0] state_hex(input perf_state_t s);
      case (s)
         IDLE:    return HEX_IDLE;
         ARMED:   return HEX_ARMED;
         RUNNING: return HEX_RUNNING;
         DONE:    return HEX_DONE;
         default: return HEX_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/perf_monitor_channel.sv
// One perf_monitor channel: start/stop PC window FSM, saturating cycle counter and sticky
// overflow flag. clear and cfg_we arrive already decoded from the top.
module perf_channel
   import perf_monitor_pkg::*;
#(
   parameter int COUNT_WIDTH = 32,
   parameter int PC_WIDTH    = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   cfg_we,
   input  perf_cfg_t              cfg,
   input  logic [PC_WIDTH-1:0]    pc,
   input  logic                   pc_valid,
   output perf_state_t            state,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   overflow
);

   perf_state_t              state_r;
   perf_state_t              state_nx_s;
   logic [COUNT_WIDTH-1:0]   count_r;
   logic [COUNT_WIDTH-1:0]   count_nx_s;
   logic                     ovf_r;
   logic                     ovf_nx_s;
   perf_cfg_t                cfg_r;
   perf_cfg_t                cfg_nx_s;
   logic [PERF_PC_MAX_W-1:0] pc_ext_s;
   logic                     start_hit_s;
   logic                     stop_hit_s;

   assign pc_ext_s    = PERF_PC_MAX_W'(pc);
   assign start_hit_s = pc_valid && (pc_ext_s == cfg_r.start_pc);
   assign stop_hit_s  = pc_valid && (pc_ext_s == cfg_r.stop_pc);

   // Channel state, count, overflow and window registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         count_r <= '0;
         ovf_r   <= 1'b0;
         cfg_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         count_r <= count_nx_s;
         ovf_r   <= ovf_nx_s;
         cfg_r   <= cfg_nx_s;
      end
   end

   // Next state: clear beats cfg_we, which beats normal window tracking.
   always_comb begin
      state_nx_s = state_r;
      if (clear) begin
         state_nx_s = IDLE;
      end else if (cfg_we) begin
         state_nx_s = ARMED;
      end else begin
         case (state_r)
            IDLE:    state_nx_s = IDLE;
            ARMED:   state_nx_s = start_hit_s ? RUNNING : ARMED;
            RUNNING: state_nx_s = stop_hit_s ? DONE : RUNNING;
            DONE:    state_nx_s = DONE;
            default: state_nx_s = IDLE;
         endcase
      end
   end

   // Datapath: the stop cycle still counts, the start cycle does not; saturate at all-ones.
   always_comb begin
      count_nx_s = count_r;
      ovf_nx_s   = ovf_r;
      cfg_nx_s   = cfg_r;
      if (clear) begin
         count_nx_s = '0;
         ovf_nx_s   = 1'b0;
      end else if (cfg_we) begin
         cfg_nx_s   = cfg;
         count_nx_s = '0;
         ovf_nx_s   = 1'b0;
      end else if (state_r == RUNNING) begin
         if (&count_r) begin
            ovf_nx_s = 1'b1;
         end else begin
            count_nx_s = count_r + COUNT_WIDTH'(1);
         end
      end else if ((state_r == ARMED) && start_hit_s) begin
         count_nx_s = '0;
      end else begin
         count_nx_s = count_r;
      end
   end

   assign state    = state_r;
   assign count    = count_r;
   assign overflow = ovf_r;

endmodule

// File: rtl/perf_monitor.sv
// Multi-channel PC-window cycle counter with a registered read port for the hex overlay.
// Optional feature macro PERF_MONITOR_SNAPSHOT_EN adds `snap` and a shadow count bank.
module perf_monitor
   import perf_monitor_pkg::*;
#(
   parameter int  NUM_CHANNELS = 4,
   parameter int  COUNT_WIDTH  = 32,
   parameter int  PC_WIDTH     = 12,
   localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PC_WIDTH-1:0]     pc,
   input  logic                    pc_valid,
   input  logic                    cfg_we,
   input  logic [CHAN_W-1:0]       cfg_chan,
   input  logic [PC_WIDTH-1:0]     cfg_start_pc,
   input  logic [PC_WIDTH-1:0]     cfg_stop_pc,
   input  logic                    clear,
`ifdef PERF_MONITOR_SNAPSHOT_EN
   input  logic                    snap,
`endif
   input  logic [CHAN_W-1:0]       rd_chan,
   output logic [COUNT_WIDTH-1:0]  rd_count,
   output logic [1:0]              rd_state,
   output logic [NUM_CHANNELS-1:0] done,
   output logic [NUM_CHANNELS-1:0] overflow
);

   perf_state_t            state_s [NUM_CHANNELS];
   logic [COUNT_WIDTH-1:0] count_s [NUM_CHANNELS];
   logic [COUNT_WIDTH-1:0] rd_src_s [NUM_CHANNELS];
   perf_cfg_t              cfg_s;
   logic [COUNT_WIDTH-1:0] rd_count_s;
   perf_state_t            rd_state_s;
   logic [COUNT_WIDTH-1:0] rd_count_r;
   perf_state_t            rd_state_r;

   assign cfg_s.start_pc = PERF_PC_MAX_W'(cfg_start_pc);
   assign cfg_s.stop_pc  = PERF_PC_MAX_W'(cfg_stop_pc);

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
      logic chan_we_s;

      // A write coinciding with clear is dropped; out-of-range channels never match.
      assign chan_we_s = cfg_we && !clear && (cfg_chan == CHAN_W'(i));

      perf_channel #(
         .COUNT_WIDTH (COUNT_WIDTH),
         .PC_WIDTH    (PC_WIDTH)
      ) u_channel (
         .clk      (clk),
         .reset    (reset),
         .clear    (clear),
         .cfg_we   (chan_we_s),
         .cfg      (cfg_s),
         .pc       (pc),
         .pc_valid (pc_valid),
         .state    (state_s[i]),
         .count    (count_s[i]),
         .overflow (overflow[i])
      );

      assign done[i] = (state_s[i] == DONE);
   end

`ifdef PERF_MONITOR_SNAPSHOT_EN
   logic [COUNT_WIDTH-1:0] shadow_r [NUM_CHANNELS];

   // Shadow bank: snap freezes every live count at once while the channels keep running.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < NUM_CHANNELS; i++) shadow_r[i] <= '0;
      end else if (snap) begin
         for (int i = 0; i < NUM_CHANNELS; i++) shadow_r[i] <= count_s[i];
      end
   end

   assign rd_src_s = shadow_r;
`else
   assign rd_src_s = count_s;
`endif

   // Read mux: a select beyond the last channel reads zero / IDLE.
   always_comb begin
      rd_count_s = '0;
      rd_state_s = IDLE;
      if (32'(rd_chan) < NUM_CHANNELS) begin
         rd_count_s = rd_src_s[rd_chan];
         rd_state_s = state_s[rd_chan];
      end else begin
         rd_count_s = '0;
         rd_state_s = IDLE;
      end
   end

   // Read port register: reflects channel contents as of the previous edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count_r <= '0;
         rd_state_r <= IDLE;
      end else begin
         rd_count_r <= rd_count_s;
         rd_state_r <= rd_state_s;
      end
   end

   assign rd_count = rd_count_r;
   assign rd_state = rd_state_r;

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: a 4-channel 32-bit instance and a 3-channel 4-bit
// instance share all inputs and are compared against a window/tick-count model.
module tb_perf_monitor;

   logic        clk = 1'b0;
   logic        reset, pc_valid, cfg_we, clear;
   logic [11:0] pc, cfg_start_pc, cfg_stop_pc;
   logic [1:0]  cfg_chan, rd_chan;

   logic [31:0] rd_count_a;
   logic [1:0]  rd_state_a;
   logic [3:0]  done_a, ovf_a;
   logic [3:0]  rd_count_b;
   logic [1:0]  rd_state_b;
   logic [2:0]  done_b, ovf_b;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   perf_monitor #(.NUM_CHANNELS(4), .COUNT_WIDTH(32), .PC_WIDTH(12)) dut_a (
      .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .cfg_we(cfg_we),
      .cfg_chan(cfg_chan), .cfg_start_pc(cfg_start_pc), .cfg_stop_pc(cfg_stop_pc),
      .clear(clear), .rd_chan(rd_chan), .rd_count(rd_count_a), .rd_state(rd_state_a),
      .done(done_a), .overflow(ovf_a));

   perf_monitor #(.NUM_CHANNELS(3), .COUNT_WIDTH(4), .PC_WIDTH(12)) dut_b (
      .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .cfg_we(cfg_we),
      .cfg_chan(cfg_chan), .cfg_start_pc(cfg_start_pc), .cfg_stop_pc(cfg_stop_pc),
      .clear(clear), .rd_chan(rd_chan), .rd_count(rd_count_b), .rd_state(rd_state_b),
      .done(done_b), .overflow(ovf_b));

   // Model: per channel a phase (0 idle,1 armed,2 running,3 done) and an unbounded tick
   // tally since the start match; saturation and overflow are derived from the tally.
   int     nch  [2] = '{4, 3};
   longint cmax [2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
   int     m_st     [2][4];
   longint m_ticks  [2][4];
   int     m_start  [2][4];
   int     m_stop   [2][4];
   longint m_rd_cnt [2];
   int     m_rd_st  [2];

   function automatic longint m_count(int d, int c);
      return (m_ticks[d][c] > cmax[d]) ? cmax[d] : m_ticks[d][c];
   endfunction

   function automatic logic [3:0] m_done(int d);
      logic [3:0] r = 4'd0;
      for (int c = 0; c < nch[d]; c++) r[c] = (m_st[d][c] == 3);
      return r;
   endfunction

   function automatic logic [3:0] m_ovf(int d);
      logic [3:0] r = 4'd0;
      for (int c = 0; c < nch[d]; c++) r[c] = (m_ticks[d][c] > cmax[d]);
      return r;
   endfunction

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_rd_cnt[d] = 0;
            m_rd_st[d]  = 0;
            for (int c = 0; c < 4; c++) begin
               m_st[d][c] = 0; m_ticks[d][c] = 0; m_start[d][c] = 0; m_stop[d][c] = 0;
            end
         end else begin
            m_rd_cnt[d] = (int'(rd_chan) < nch[d]) ? m_count(d, int'(rd_chan)) : 0;
            m_rd_st[d]  = (int'(rd_chan) < nch[d]) ? m_st[d][rd_chan] : 0;
            for (int c = 0; c < nch[d]; c++) begin
               if (clear) begin
                  m_st[d][c] = 0; m_ticks[d][c] = 0;
               end else if (cfg_we && int'(cfg_chan) == c) begin
                  m_start[d][c] = int'(cfg_start_pc); m_stop[d][c] = int'(cfg_stop_pc);
                  m_ticks[d][c] = 0; m_st[d][c] = 1;
               end else if (m_st[d][c] == 1) begin
                  if (pc_valid && int'(pc) == m_start[d][c]) begin
                     m_st[d][c] = 2; m_ticks[d][c] = 0;
                  end
               end else if (m_st[d][c] == 2) begin
                  m_ticks[d][c]++;
                  if (pc_valid && int'(pc) == m_stop[d][c]) m_st[d][c] = 3;
               end
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc_valid = 1'b0; pc = 12'd0; cfg_we = 1'b0; clear = 1'b0;
      cfg_chan = 2'd0; cfg_start_pc = 12'd0; cfg_stop_pc = 12'd0;
   endtask

   task automatic configure(input logic [1:0] ch, input logic [11:0] s, input logic [11:0] e);
      cfg_we = 1'b1; cfg_chan = ch; cfg_start_pc = s; cfg_stop_pc = e;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic hit(input logic [11:0] addr, input logic valid);
      pc = addr; pc_valid = valid;
      tick();
      pc_valid = 1'b0; pc = 12'd0;
   endtask

   task automatic test_reset();
      idle_inputs(); rd_chan = 2'd0; reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      n_checks++; if (done_a !== 4'd0) $display("FAIL reset_done_a got=%b exp=0000", done_a); else n_pass++;
      n_checks++; if (ovf_a !== 4'd0) $display("FAIL reset_ovf_a got=%b exp=0000", ovf_a); else n_pass++;
      n_checks++; if (rd_count_a !== 32'd0) $display("FAIL reset_rd_count_a got=%0d exp=0", rd_count_a); else n_pass++;
      n_checks++; if (rd_state_a !== 2'd0) $display("FAIL reset_rd_state_a got=%0d exp=0", rd_state_a); else n_pass++;
      n_checks++; if ({done_b, ovf_b, rd_count_b} !== 10'd0) $display("FAIL reset_b got=%b exp=0", {done_b, ovf_b, rd_count_b}); else n_pass++;
   endtask

   task automatic test_single_run();
      configure(2'd0, 12'h010, 12'h020);
      hit(12'h010, 1'b1);
      repeat (99) tick();
      hit(12'h020, 1'b1);
      n_checks++; if (done_a[0] !== 1'b1) $display("FAIL run_done0 got=%b exp=1", done_a[0]); else n_pass++;
      rd_chan = 2'd0;
      tick();
      n_checks++; if (rd_count_a !== 32'd100) $display("FAIL run_rd_count got=%0d exp=100", rd_count_a); else n_pass++;
      n_checks++; if (rd_state_a !== 2'd3) $display("FAIL run_rd_state got=%0d exp=3", rd_state_a); else n_pass++;
      n_checks++; if (rd_count_b !== 4'd15) $display("FAIL run_sat_b got=%0d exp=15", rd_count_b); else n_pass++;
      n_checks++; if (ovf_a[0] !== 1'b0) $display("FAIL run_ovf_a got=%b exp=0", ovf_a[0]); else n_pass++;
   endtask

   task automatic test_saturation();
      configure(2'd0, 12'h030, 12'h031);
      hit(12'h030, 1'b1);
      repeat (20) tick();
      rd_chan = 2'd0;
      tick();
      n_checks++; if (rd_count_b !== 4'd15) $display("FAIL sat_count_b got=%0d exp=15", rd_count_b); else n_pass++;
      n_checks++; if (ovf_b[0] !== 1'b1) $display("FAIL sat_ovf_b got=%b exp=1", ovf_b[0]); else n_pass++;
      n_checks++; if (rd_count_a !== 32'd20) $display("FAIL sat_count_a got=%0d exp=20", rd_count_a); else n_pass++;
      configure(2'd0, 12'h030, 12'h031);
      n_checks++; if (ovf_b[0] !== 1'b0) $display("FAIL sat_ovf_cleared got=%b exp=0", ovf_b[0]); else n_pass++;
      tick();
      n_checks++; if (rd_state_b !== 2'd1) $display("FAIL sat_rearmed got=%0d exp=1", rd_state_b); else n_pass++;
   endtask

   task automatic test_same_start_stop();
      configure(2'd1, 12'h005, 12'h005);
      hit(12'h005, 1'b1);
      repeat (6) tick();
      hit(12'h005, 1'b1);
      n_checks++; if (done_a[1] !== 1'b1) $display("FAIL eq_done1 got=%b exp=1", done_a[1]); else n_pass++;
      rd_chan = 2'd1;
      tick();
      n_checks++; if (rd_count_a !== 32'd7) $display("FAIL eq_count_a got=%0d exp=7", rd_count_a); else n_pass++;
      n_checks++; if (rd_count_b !== 4'd7) $display("FAIL eq_count_b got=%0d exp=7", rd_count_b); else n_pass++;
   endtask

   task automatic test_clear_priority();
      configure(2'd2, 12'h040, 12'h041);
      clear = 1'b1; cfg_we = 1'b1; cfg_chan = 2'd2; cfg_start_pc = 12'h050; cfg_stop_pc = 12'h051;
      tick();
      clear = 1'b0; cfg_we = 1'b0;
      n_checks++; if ({done_a, ovf_a} !== 8'd0) $display("FAIL clr_flags_a got=%b exp=0", {done_a, ovf_a}); else n_pass++;
      n_checks++; if ({done_b, ovf_b} !== 6'd0) $display("FAIL clr_flags_b got=%b exp=0", {done_b, ovf_b}); else n_pass++;
      for (int r = 0; r < 4; r++) begin
         rd_chan = 2'(r);
         tick();
         n_checks++; if (rd_state_a !== 2'd0) $display("FAIL clr_state ch%0d got=%0d exp=0", r, rd_state_a); else n_pass++;
         n_checks++; if (rd_count_a !== 32'd0) $display("FAIL clr_count ch%0d got=%0d exp=0", r, rd_count_a); else n_pass++;
      end
   endtask

   task automatic test_overlap();
      for (int c = 0; c < 4; c++) configure(2'(c), 12'h100 + 12'(c), 12'h200 + 12'(c));
      for (int c = 0; c < 4; c++) hit(12'h100 + 12'(c), 1'b1);
      repeat (3) tick();
      hit(12'h200, 1'b1);
      hit(12'h201, 1'b0);
      hit(12'h202, 1'b1);
      hit(12'h203, 1'b1);
      n_checks++; if (done_a !== 4'b1101) $display("FAIL ovl_done_a got=%b exp=1101", done_a); else n_pass++;
      n_checks++; if (done_b !== 3'b101) $display("FAIL ovl_done_b got=%b exp=101", done_b); else n_pass++;
      rd_chan = 2'd1;
      tick();
      n_checks++; if (rd_state_a !== 2'd2) $display("FAIL ovl_ch1_running got=%0d exp=2", rd_state_a); else n_pass++;
      rd_chan = 2'd3;
      tick();
      n_checks++; if ({rd_state_b, rd_count_b} !== 6'd0) $display("FAIL ovl_b_oob_read got=%b exp=0", {rd_state_b, rd_count_b}); else n_pass++;
      n_checks++; if (rd_count_a !== 32'(m_rd_cnt[0])) $display("FAIL ovl_ch3_count got=%0d exp=%0d", rd_count_a, m_rd_cnt[0]); else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0] exp4;
      for (int i = 0; i < 600; i++) begin
         cfg_we       = ($urandom_range(0, 7) == 0);
         cfg_chan     = 2'($urandom_range(0, 3));
         cfg_start_pc = 12'($urandom_range(0, 7));
         cfg_stop_pc  = 12'($urandom_range(0, 7));
         clear        = ($urandom_range(0, 79) == 0);
         pc           = 12'($urandom_range(0, 7));
         pc_valid     = ($urandom_range(0, 2) != 0);
         rd_chan      = 2'($urandom_range(0, 3));
         tick();
         n_checks++; if (rd_count_a !== 32'(m_rd_cnt[0])) $display("FAIL rnd_count_a cyc=%0d got=%0d exp=%0d", i, rd_count_a, m_rd_cnt[0]); else n_pass++;
         n_checks++; if (rd_state_a !== 2'(m_rd_st[0])) $display("FAIL rnd_state_a cyc=%0d got=%0d exp=%0d", i, rd_state_a, m_rd_st[0]); else n_pass++;
         n_checks++; if ({28'd0, rd_count_b} !== 32'(m_rd_cnt[1])) $display("FAIL rnd_count_b cyc=%0d got=%0d exp=%0d", i, rd_count_b, m_rd_cnt[1]); else n_pass++;
         n_checks++; if (rd_state_b !== 2'(m_rd_st[1])) $display("FAIL rnd_state_b cyc=%0d got=%0d exp=%0d", i, rd_state_b, m_rd_st[1]); else n_pass++;
         exp4 = m_done(0);
         n_checks++; if (done_a !== exp4) $display("FAIL rnd_done_a cyc=%0d got=%b exp=%b", i, done_a, exp4); else n_pass++;
         exp4 = m_ovf(0);
         n_checks++; if (ovf_a !== exp4) $display("FAIL rnd_ovf_a cyc=%0d got=%b exp=%b", i, ovf_a, exp4); else n_pass++;
         exp4 = m_done(1);
         n_checks++; if ({1'b0, done_b} !== exp4) $display("FAIL rnd_done_b cyc=%0d got=%b exp=%b", i, done_b, exp4); else n_pass++;
         exp4 = m_ovf(1);
         n_checks++; if ({1'b0, ovf_b} !== exp4) $display("FAIL rnd_ovf_b cyc=%0d got=%b exp=%b", i, ovf_b, exp4); else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset   = 1'b1;
      rd_chan = 2'd0;
      test_reset();
      test_single_run();
      test_saturation();
      test_same_start_stop();
      test_clear_priority();
      test_overlap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
